// File: rtl/ifetch_unit.sv
// Instruction-fetch / PC-update stage: fetches one word per hand-off and
// selects the next PC from the executor's resolution when downstream takes it.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           Instruction,
  output logic [31:0]           pc,
  output logic [31:0]           branch_base,
  output logic [31:0]           link_addr,
  output logic                  inst_valid,
  input  logic                  inst_taken,
  input  logic [31:0]           AddrResult,
  input  logic                  Zero,
  input  logic                  Branch,
  input  logic                  nBranch,
  input  logic                  Jmp,
  input  logic                  Jal,
  input  logic                  Jr,
  output logic                  addr_misalign,
  output logic [1:0]            fsm_state_o
);

  // Handshake: a fetch completes in the cycle imem_req=1 and imem_ack=1;
  // a hand-off completes in the cycle inst_valid=1 and inst_taken=1, and
  // the resolution inputs are sampled only in that cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] link_q;
  logic        req_q;
  logic        valid_q;
  logic        misalign_q;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc_d;
  logic        misalign_d;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc_d  = pc_plus4;
    misalign_d = 1'b0;
    if (Jr) begin
      next_pc_d  = {AddrResult[31:2], 2'b00};
      misalign_d = (AddrResult[1:0] != 2'b00);
    end else if (Jmp || Jal) begin
      next_pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if ((Branch && Zero) || (nBranch && !Zero)) begin
      next_pc_d = {AddrResult[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      link_q     <= 32'd0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (inst_taken) begin
            pc_q       <= next_pc_d;
            link_q     <= pc_plus4;
            misalign_q <= misalign_d;
            state_q    <= REQ;
            req_q      <= 1'b1;
            valid_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q[ADDR_WIDTH+1:2];
  assign Instruction   = instr_q;
  assign pc            = pc_q;
  assign branch_base   = pc_plus4;
  assign link_addr     = link_q;
  assign inst_valid    = valid_q;
  assign addr_misalign = misalign_q;
  assign fsm_state_o   = state_q;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch and PC-update stage. It issues word fetches to instruction memory and presents each instruction to decode/execute.
- On hand-off it consumes the executor's resolution (AddrResult, Zero, control flags) to select the next PC.
- It produces the PC+4 value that the executor uses as its branch base, plus the jal link address.
- Multi-cycle: memory may insert wait states, and downstream may hold an instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
ADDR_WIDTH, 14, instruction-memory word-address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_WIDTH  word address, equal to pc[ADDR_WIDTH+1:2]
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
Instruction  out  32  current instruction
pc  out  32  address of Instruction
branch_base  out  32  pc+4, feeds the executor's pc input
link_addr  out  32  pc+4 registered at hand-off, used as jal write-back value
inst_valid  out  1  Instruction is valid and held
inst_taken  in  1  downstream accepts Instruction; resolution inputs valid this cycle
AddrResult  in  32  branch target, or rs value for jr, from the executor
Zero  in  1  executor zero flag
Branch  in  1  beq
nBranch  in  1  bne
Jmp  in  1  j
Jal  in  1  jal
Jr  in  1  jr
addr_misalign  out  1  one-cycle pulse: jr target had nonzero [1:0]

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC; state=IDLE; imem_req=0; inst_valid=0.
  - Instruction, link_addr and addr_misalign are all 0.
  - imem_req drops in the same instant, even mid-fetch.
  - An imem_ack arriving during or after reset while in IDLE is ignored.
- All outputs are registered except branch_base and imem_addr, which are combinational from pc.
- FSM states:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1; imem_addr stable at pc[ADDR_WIDTH+1:2].
    - imem_ack=1 → Instruction<=imem_rdata; go to VALID.
    - Otherwise stay in REQ. There is no timeout.
    - An ack in the first REQ cycle is legal.
  - VALID: inst_valid=1; Instruction and pc held.
    - inst_taken=0 → stay; the resolution inputs are ignored.
    - inst_taken=1 → pc<=next_pc; link_addr<=pc+4; go to REQ.
- Latency: with zero memory wait states and inst_taken asserted on first valid, the fetch period is 2 cycles (REQ, VALID).
- imem_req is 0 outside REQ. imem_ack outside REQ is ignored.
- next_pc priority (highest first), evaluated only when inst_taken=1:
  1. Jr: {AddrResult[31:2],2'b00}. addr_misalign pulses the next cycle if AddrResult[1:0]!=0.
  2. Jmp or Jal: {branch_base[31:28], Instruction[25:0], 2'b00}.
  3. Branch and Zero=1 → AddrResult.
  4. nBranch and Zero=0 → AddrResult.
  5. Otherwise pc+4.
- Several flags high at once resolves by the priority above; Branch with nBranch both high resolves by Zero per rows 3/4.
- Branch/nBranch target bits [1:0] are forced to 0.
- pc+4 arithmetic is unsigned 32-bit; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- imem_addr drops the upper PC bits (truncation, no fault).
- link_addr updates on every hand-off, not only on jal. The register file write is gated by Jal downstream.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: release rst_n; imem_ack=1 immediately each REQ; imem_rdata=0x20080005, 0x00000000; inst_taken=1 whenever valid, no flags.
  - Required: pc=0,4,8; imem_addr=0,1,2; inst_valid every second cycle.
- Wait states and downstream stall:
  - Stimulus: ack delayed 3 cycles; inst_taken held 0 for 2 cycles.
  - Required: imem_req high 4 cycles with stable addr; Instruction unchanged while stalled; pc advances only on taken.
- Conditional branches:
  - Stimulus: pc=0x10; Branch=1, Zero=1, AddrResult=0x40.
  - Required: next pc=0x40.
  - Stimulus: nBranch=1, Zero=1.
  - Required: next pc=0x14.
- Jump and link:
  - Stimulus: pc=0x1000_0020; Instruction=0x0C000010; Jal=1.
  - Required: pc=0x1000_0040; link_addr=0x1000_0024.
- Jump register:
  - Stimulus: Jr=1, AddrResult=0x0000_0103.
  - Required: pc=0x100; addr_misalign pulses 1 cycle.
  - Stimulus: Jr=1 and Branch=1 together.
  - Required: Jr wins.
- Reset mid-fetch and wrap:
  - Stimulus: assert rst_n=0 while in REQ with ack pending.
  - Required: imem_req=0 immediately; pc=RESET_PC.
  - Stimulus: pc=0xFFFF_FFFC, sequential.
  - Required: next pc=0.
